// File: rtl/lm_sm_sequencer.sv
// lm_sm_sequencer
//
// Decode-side sequencer between the fetch/decode and decode/register-read
// pipeline registers. Ordinary instructions pass straight through. A
// load-multiple or store-multiple is expanded into one micro-op per set bit
// of its register list (lowest register first), and fetch is stalled until
// the last micro-op has been issued.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   IR             instruction from pipeline register 1
//   hold           downstream stall, freezes the sequencer
//   flush          branch/jump flush, aborts any sequence and injects a NOP
//   out_IR         instruction to pipeline register 2
//   uop_reg        register index of the current micro-op
//   uop_offset     word offset from the base register of the current micro-op
//   first_multiple current micro-op is the first of its multiple
//   last_multiple  current micro-op is the last of its multiple
//   mem_rd         micro-op is a load-multiple transfer
//   mem_wr         micro-op is a store-multiple transfer
//   stall_fetch    hold PC and pipeline register 1 this cycle
//   busy           a multiple is being expanded (SEQ state)

module lm_sm_sequencer #(
    parameter logic [15:0] NOP_IR = 16'hF000,
    parameter logic [3:0]  OPC_LM = 4'b0110,
    parameter logic [3:0]  OPC_SM = 4'b0111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] IR,
    input  logic        hold,
    input  logic        flush,
    output logic [15:0] out_IR,
    output logic [2:0]  uop_reg,
    output logic [2:0]  uop_offset,
    output logic        first_multiple,
    output logic        last_multiple,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        stall_fetch,
    output logic        busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEQ  = 1'b1
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  mask_r;
    logic [7:0]  mask_s;
    logic [2:0]  offset_r;
    logic [2:0]  offset_s;
    logic [15:0] saved_ir_r;
    logic [15:0] saved_ir_s;

    logic [15:0] cur_ir_s;
    logic [7:0]  list_s;
    logic [2:0]  sel_s;
    logic [7:0]  rest_s;
    logic        is_lm_s;
    logic        is_sm_s;

    // Index of the lowest set bit; scanning downward lets the lowest bit win.
    function automatic logic [2:0] lowest_set_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (vec[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Select the source instruction/list and locate the next register.
    always_comb begin
        if (state_r == SEQ) begin
            cur_ir_s = saved_ir_r;
            list_s   = mask_r;
        end else begin
            cur_ir_s = IR;
            list_s   = IR[7:0];
        end
        is_lm_s = (cur_ir_s[15:12] == OPC_LM);
        is_sm_s = (cur_ir_s[15:12] == OPC_SM);
        sel_s   = lowest_set_index(list_s);
        rest_s  = list_s & ~(8'b0000_0001 << sel_s);
    end

    // Next-state and output decode; flush overrides hold, reset overrides all.
    always_comb begin
        state_s        = state_r;
        mask_s         = mask_r;
        offset_s       = offset_r;
        saved_ir_s     = saved_ir_r;
        out_IR         = cur_ir_s;
        uop_reg        = 3'd0;
        uop_offset     = 3'd0;
        first_multiple = 1'b0;
        last_multiple  = 1'b0;
        mem_rd         = 1'b0;
        mem_wr         = 1'b0;
        stall_fetch    = 1'b0;
        busy           = 1'b0;

        if (!reset) begin
            out_IR = NOP_IR;
        end else if (flush) begin
            out_IR   = NOP_IR;
            busy     = (state_r == SEQ);
            state_s  = IDLE;
            mask_s   = 8'h00;
            offset_s = 3'd0;
        end else begin
            busy = (state_r == SEQ);
            case (state_r)
                IDLE: begin
                    if (!(is_lm_s || is_sm_s)) begin
                        out_IR = IR;
                    end else if (list_s == 8'h00) begin
                        out_IR = NOP_IR;
                    end else begin
                        uop_reg        = sel_s;
                        uop_offset     = 3'd0;
                        first_multiple = 1'b1;
                        mem_rd         = is_lm_s;
                        mem_wr         = is_sm_s;
                        if (rest_s != 8'h00) begin
                            stall_fetch = 1'b1;
                            state_s     = SEQ;
                            mask_s      = rest_s;
                            offset_s    = 3'd1;
                            saved_ir_s  = IR;
                        end else begin
                            last_multiple = 1'b1;
                        end
                    end
                end
                SEQ: begin
                    uop_reg    = sel_s;
                    uop_offset = offset_r;
                    mem_rd     = is_lm_s;
                    mem_wr     = is_sm_s;
                    if (rest_s != 8'h00) begin
                        stall_fetch = 1'b1;
                        mask_s      = rest_s;
                        offset_s    = offset_r + 3'd1;
                    end else begin
                        last_multiple = 1'b1;
                        state_s       = IDLE;
                        mask_s        = 8'h00;
                    end
                end
                default: begin
                    out_IR   = NOP_IR;
                    state_s  = IDLE;
                    mask_s   = 8'h00;
                    offset_s = 3'd0;
                end
            endcase

            // A downstream stall freezes all state so the same micro-op repeats.
            if (hold) begin
                state_s     = state_r;
                mask_s      = mask_r;
                offset_s    = offset_r;
                saved_ir_s  = saved_ir_r;
                stall_fetch = 1'b1;
            end else begin
                stall_fetch = stall_fetch;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            mask_r     <= 8'h00;
            offset_r   <= 3'd0;
            saved_ir_r <= NOP_IR;
        end else begin
            state_r    <= state_s;
            mask_r     <= mask_s;
            offset_r   <= offset_s;
            saved_ir_r <= saved_ir_s;
        end
    end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Testbench for lm_sm_sequencer: directed stimulus with hand-computed
// expected outputs queued by the driver and compared by an independent
// monitor on the falling clock edge.

module tb_lm_sm_sequencer;

    logic        clk;
    logic        reset;
    logic [15:0] IR;
    logic        hold;
    logic        flush;
    logic [15:0] out_IR;
    logic [2:0]  uop_reg;
    logic [2:0]  uop_offset;
    logic        first_multiple;
    logic        last_multiple;
    logic        mem_rd;
    logic        mem_wr;
    logic        stall_fetch;
    logic        busy;

    typedef struct {
        string       name;
        logic [27:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   checks_r;
    int   errors_r;
    logic drive_done_r;

    lm_sm_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .IR             (IR),
        .hold           (hold),
        .flush          (flush),
        .out_IR         (out_IR),
        .uop_reg        (uop_reg),
        .uop_offset     (uop_offset),
        .first_multiple (first_multiple),
        .last_multiple  (last_multiple),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .stall_fetch    (stall_fetch),
        .busy           (busy)
    );

    // 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Apply inputs just after a rising edge.
    task automatic drive(input logic rst_v, input logic [15:0] ir_v,
                         input logic hold_v, input logic flush_v);
        @(posedge clk);
        #1;
        reset = rst_v;
        IR    = ir_v;
        hold  = hold_v;
        flush = flush_v;
    endtask

    // Queue the expected output bundle for the cycle just driven.
    task automatic expect_out(input string nm, input logic [15:0] ir_v,
                              input logic [2:0] rg, input logic [2:0] off,
                              input logic f, input logic l, input logic rd,
                              input logic wr, input logic st, input logic bz);
        exp_t e;
        e.name = nm;
        e.vec  = {ir_v, rg, off, f, l, rd, wr, st, bz};
        exp_q.push_back(e);
    endtask

    // Monitor: compare DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        logic [27:0] act;
        exp_t        e;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {out_IR, uop_reg, uop_offset, first_multiple, last_multiple,
                   mem_rd, mem_wr, stall_fetch, busy};
            checks_r = checks_r + 1;
            if (act !== e.vec) begin
                errors_r = errors_r + 1;
                $display("FAIL %s got ir=%h reg=%0d off=%0d f=%b l=%b rd=%b wr=%b st=%b busy=%b exp ir=%h reg=%0d off=%0d f=%b l=%b rd=%b wr=%b st=%b busy=%b",
                         e.name, act[27:12], act[11:9], act[8:6], act[5], act[4], act[3], act[2], act[1], act[0],
                         e.vec[27:12], e.vec[11:9], e.vec[8:6], e.vec[5], e.vec[4], e.vec[3], e.vec[2], e.vec[1], e.vec[0]);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    // Directed stimulus.
    initial begin
        checks_r     = 0;
        errors_r     = 0;
        drive_done_r = 1'b0;
        reset        = 1'b0;
        IR           = 16'h60A5;
        hold         = 1'b0;
        flush        = 1'b0;

        // Reset held with an LM on the input.
        drive(1'b0, 16'h60A5, 1'b0, 1'b0);
        expect_out("reset_lm", 16'hF000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h1050, 1'b0, 1'b0);
        expect_out("reset_release_add", 16'h1050, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // LM, list 1010_0101.
        drive(1'b1, 16'h60A5, 1'b0, 1'b0);
        expect_out("lm_a5_c1", 16'h60A5, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 16'h60A5, 1'b0, 1'b0);
        expect_out("lm_a5_c2", 16'h60A5, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h60A5, 1'b0, 1'b0);
        expect_out("lm_a5_c3", 16'h60A5, 3'd5, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h60A5, 1'b0, 1'b0);
        expect_out("lm_a5_c4", 16'h60A5, 3'd7, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // SM, single register 7.
        drive(1'b1, 16'h7080, 1'b0, 1'b0);
        expect_out("sm_80", 16'h7080, 3'd7, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 16'h1050, 1'b0, 1'b0);
        expect_out("after_sm_80", 16'h1050, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // LM, list 0F, hold for three cycles on the second micro-op.
        drive(1'b1, 16'h600F, 1'b0, 1'b0);
        expect_out("lm_0f_c1", 16'h600F, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h600F, 1'b1, 1'b0);
            expect_out("lm_0f_hold", 16'h600F, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        end
        drive(1'b1, 16'h600F, 1'b0, 1'b0);
        expect_out("lm_0f_c5", 16'h600F, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h600F, 1'b0, 1'b0);
        expect_out("lm_0f_c6", 16'h600F, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h600F, 1'b0, 1'b0);
        expect_out("lm_0f_c7", 16'h600F, 3'd3, 3'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

        // LM, list FF, flushed in the third cycle.
        drive(1'b1, 16'h60FF, 1'b0, 1'b0);
        expect_out("lm_ff_c1", 16'h60FF, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 16'h60FF, 1'b0, 1'b0);
        expect_out("lm_ff_c2", 16'h60FF, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 16'h60FF, 1'b0, 1'b1);
        expect_out("lm_ff_flush", 16'hF000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 16'h1050, 1'b0, 1'b0);
        expect_out("after_flush", 16'h1050, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Empty-list LM becomes a NOP without stalling.
        drive(1'b1, 16'h6000, 1'b0, 1'b0);
        expect_out("lm_empty", 16'hF000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // SM, list 03, with hold and flush together: flush wins.
        drive(1'b1, 16'h7003, 1'b1, 1'b1);
        expect_out("sm_03_hold_flush", 16'hF000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h1050, 1'b0, 1'b0);
        expect_out("after_hold_flush", 16'h1050, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset asserted mid-sequence aborts the multiple.
        drive(1'b1, 16'h60FF, 1'b0, 1'b0);
        expect_out("lm_ff2_c1", 16'h60FF, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 16'h60FF, 1'b0, 1'b0);
        expect_out("lm_ff2_c2", 16'h60FF, 3'd1, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        drive(1'b0, 16'h60FF, 1'b0, 1'b0);
        expect_out("mid_reset", 16'hF000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 16'h1050, 1'b0, 1'b0);
        expect_out("after_mid_reset", 16'h1050, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Let the monitor drain the queue.
        @(posedge clk);
        @(negedge clk);
        #1;
        checks_r = checks_r + 1;
        if (exp_q.size() != 0) begin
            errors_r = errors_r + 1;
            $display("FAIL queue_drain got %0d pending exp 0 pending", exp_q.size());
        end
        drive_done_r = 1'b1;
        $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
        $finish;
    end

endmodule
